// File: rtl/assert_next_defs.sv
// Shared constants for the assert_next checker family.
// Fire-bit positions and the legal window-length limit.
package assert_next_defs;

  localparam int FIRE_NO_TEST       = 0;
  localparam int FIRE_OVERLAP       = 1;
  localparam int FIRE_MISSING_START = 2;
  localparam int FIRE_W             = 3;
  localparam int NUM_CKS_MAX        = 64;

  typedef logic [FIRE_W-1:0] fire_t;

  // Out-of-range window lengths fall back to a single-cycle window.
  function automatic int eff_num_cks(input int n);
    return (n < 1 || n > NUM_CKS_MAX) ? 1 : n;
  endfunction

endpackage

// File: rtl/ovl_sat_counter.sv
// Saturating up-counter used for checker coverage.
// Clears on reset, counts on inc, holds at all-ones.
module ovl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/assert_next_window_engine.sv
// Evaluation engine for the "next" check: test_expr must be
// high exactly NUM_CKS cycles after every start_event.
module assert_next_window_engine
  import assert_next_defs::*;
#(
  parameter int NUM_CKS             = 3,
  parameter int CHECK_OVERLAPPING   = 1,
  parameter int CHECK_MISSING_START = 1,
  parameter int CNT_W               = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_event,
  input  logic              test_expr,
  output logic [FIRE_W-1:0] fire,
  output logic              no_overlapping,
  output logic [CNT_W-1:0]  cov_windows_ok,
  output logic [CNT_W-1:0]  cov_overlaps
);

  localparam int NK = eff_num_cks(NUM_CKS);

  if (NUM_CKS < 1 || NUM_CKS > NUM_CKS_MAX) begin : g_bad_num_cks
    $error("ovl_error_t: NUM_CKS=%0d outside 1..%0d", NUM_CKS, NUM_CKS_MAX);
  end

  logic          start;
  logic          test;
  logic [NK-1:0] sr;
  logic          due;
  logic          pending;
  fire_t         fire_d;
  logic          ok_inc;
  logic          ovl_inc;

  // Unknown inputs count as low.
  assign start = (start_event === 1'b1);
  assign test  = (test_expr === 1'b1);

  if (NK == 1) begin : g_sr1
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sr <= '0;
      else       sr <= start;
    end
    assign pending = 1'b0;
  end else begin : g_srn
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sr <= '0;
      else       sr <= {sr[NK-2:0], start};
    end
    assign pending = |sr[NK-2:0];
  end

  assign due            = sr[NK-1];
  assign no_overlapping = ~pending;

  always_comb begin
    fire_d = '0;
    fire_d[FIRE_NO_TEST] = due & ~test;
    fire_d[FIRE_OVERLAP] =
      (CHECK_OVERLAPPING != 0) & start & pending;
    fire_d[FIRE_MISSING_START] =
      (CHECK_MISSING_START != 0) & test & ~due;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fire <= '0;
    else       fire <= fire_d;
  end

  assign ok_inc  = due & test;
  assign ovl_inc = start & pending;

  ovl_sat_counter #(.CNT_W(CNT_W)) u_cov_ok (
    .clk   (clk),
    .reset (reset),
    .inc   (ok_inc),
    .count (cov_windows_ok)
  );

  ovl_sat_counter #(.CNT_W(CNT_W)) u_cov_ovl (
    .clk   (clk),
    .reset (reset),
    .inc   (ovl_inc),
    .count (cov_overlaps)
  );

endmodule

// File: tb/tb_assert_next_window_engine.sv
// Scoreboard bench for assert_next_window_engine.
// Four parameterisations share clock and reset.
module tb_assert_next_window_engine;

  typedef struct {
    int         cyc;
    int         dut;
    int         tid;
    logic [2:0] f;
    logic       no;
    int         cw;
    int         co;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  st;
  logic [3:0]  te;
  logic [2:0]  f0, f1, f2, f3;
  logic        n0, n1, n2, n3;
  logic [31:0] w0, o0, w1, o1, w2, o2;
  logic [3:0]  w3, o3;

  exp_t q[$];
  int   cyc = 0;
  int   tid = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assert_next_window_engine #(
    .NUM_CKS(3), .CHECK_OVERLAPPING(1),
    .CHECK_MISSING_START(1), .CNT_W(32)
  ) d0 (
    .clk(clk), .reset(reset),
    .start_event(st[0]), .test_expr(te[0]),
    .fire(f0), .no_overlapping(n0),
    .cov_windows_ok(w0), .cov_overlaps(o0)
  );

  assert_next_window_engine #(
    .NUM_CKS(3), .CHECK_OVERLAPPING(0),
    .CHECK_MISSING_START(1), .CNT_W(32)
  ) d1 (
    .clk(clk), .reset(reset),
    .start_event(st[1]), .test_expr(te[1]),
    .fire(f1), .no_overlapping(n1),
    .cov_windows_ok(w1), .cov_overlaps(o1)
  );

  assert_next_window_engine #(
    .NUM_CKS(3), .CHECK_OVERLAPPING(1),
    .CHECK_MISSING_START(0), .CNT_W(32)
  ) d2 (
    .clk(clk), .reset(reset),
    .start_event(st[2]), .test_expr(te[2]),
    .fire(f2), .no_overlapping(n2),
    .cov_windows_ok(w2), .cov_overlaps(o2)
  );

  assert_next_window_engine #(
    .NUM_CKS(1), .CHECK_OVERLAPPING(1),
    .CHECK_MISSING_START(1), .CNT_W(4)
  ) d3 (
    .clk(clk), .reset(reset),
    .start_event(st[3]), .test_expr(te[3]),
    .fire(f3), .no_overlapping(n3),
    .cov_windows_ok(w3), .cov_overlaps(o3)
  );

  task automatic push_exp(input int d, input logic [2:0] f,
                          input logic no, input int cw, input int co);
    exp_t e;
    e.cyc = cyc + 1;
    e.dut = d;
    e.tid = tid;
    e.f   = f;
    e.no  = no;
    e.cw  = cw;
    e.co  = co;
    q.push_back(e);
  endtask

  // Drive one sample edge and queue what must be seen after it.
  task automatic step(input int d, input logic s, input logic t,
                      input logic [2:0] f, input logic no,
                      input int cw, input int co);
    @(negedge clk);
    st = '0;
    te = '0;
    st[d[1:0]] = s;
    te[d[1:0]] = t;
    push_exp(d, f, no, cw, co);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    st = '0;
    te = '0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk(input string nm, input exp_t e,
                     input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL t%0d dut%0d %s cyc%0d: got %0d expected %0d",
               e.tid, e.dut, nm, e.cyc, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t        e;
        logic [2:0]  af;
        logic        an;
        logic [31:0] aw;
        logic [31:0] ao;
        e = q.pop_front();
        case (e.dut)
          0: begin af = f0; an = n0; aw = w0; ao = o0; end
          1: begin af = f1; an = n1; aw = w1; ao = o1; end
          2: begin af = f2; an = n2; aw = w2; ao = o2; end
          default: begin
            af = f3; an = n3;
            aw = {28'd0, w3}; ao = {28'd0, o3};
          end
        endcase
        chk("fire", e, {29'd0, af}, {29'd0, e.f});
        chk("no_overlapping", e, {31'd0, an}, {31'd0, e.no});
        chk("cov_windows_ok", e, aw, e.cw);
        chk("cov_overlaps", e, ao, e.co);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    st = '0;
    te = '0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;

    // reset state
    tid = 0;
    step(0, 0, 0, 3'd0, 1, 0, 0);

    // satisfied window
    tid = 1;
    step(0, 1, 0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 1, 0, 0);
    step(0, 0, 1, 3'd0, 1, 1, 0);
    step(0, 0, 0, 3'd0, 1, 1, 0);

    // missing test_expr
    do_reset();
    tid = 2;
    step(0, 1, 0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 1, 0, 0);
    step(0, 0, 0, 3'b001, 1, 0, 0);
    step(0, 0, 0, 3'd0, 1, 0, 0);

    // overlapping starts, check enabled
    do_reset();
    tid = 3;
    step(0, 1, 0, 3'd0, 0, 0, 0);
    step(0, 1, 0, 3'b010, 0, 0, 1);
    step(0, 0, 0, 3'd0, 0, 0, 1);
    step(0, 0, 1, 3'd0, 1, 1, 1);
    step(0, 0, 1, 3'd0, 1, 2, 1);
    step(0, 0, 0, 3'd0, 1, 2, 1);

    // overlapping starts, check disabled
    do_reset();
    tid = 4;
    step(1, 1, 0, 3'd0, 0, 0, 0);
    step(1, 1, 0, 3'd0, 0, 0, 1);
    step(1, 0, 0, 3'd0, 0, 0, 1);
    step(1, 0, 1, 3'd0, 1, 1, 1);
    step(1, 0, 1, 3'd0, 1, 2, 1);
    step(1, 0, 0, 3'd0, 1, 2, 1);

    // start on the due cycle is not an overlap
    do_reset();
    tid = 5;
    step(0, 1, 0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 1, 0, 0);
    step(0, 1, 1, 3'd0, 0, 1, 0);
    step(0, 0, 0, 3'd0, 0, 1, 0);
    step(0, 0, 0, 3'd0, 1, 1, 0);
    step(0, 0, 1, 3'd0, 1, 2, 0);
    step(0, 0, 0, 3'd0, 1, 2, 0);

    // test_expr without a start
    tid = 6;
    step(0, 0, 1, 3'b100, 1, 2, 0);
    step(0, 0, 0, 3'd0, 1, 2, 0);

    // missing-start check disabled
    do_reset();
    tid = 7;
    step(2, 0, 1, 3'd0, 1, 0, 0);
    step(2, 0, 0, 3'd0, 1, 0, 0);

    // several bits in one cycle, then two misses
    do_reset();
    tid = 8;
    step(0, 1, 0, 3'd0, 0, 0, 0);
    step(0, 1, 1, 3'b110, 0, 0, 1);
    step(0, 0, 0, 3'd0, 0, 0, 1);
    step(0, 0, 0, 3'b001, 1, 0, 1);
    step(0, 0, 0, 3'b001, 1, 0, 1);
    step(0, 0, 0, 3'd0, 1, 0, 1);

    // asynchronous reset mid-window drops the window
    do_reset();
    tid = 9;
    step(0, 1, 0, 3'd0, 0, 0, 0);
    @(negedge clk);
    st = '0;
    te = '0;
    push_exp(0, 3'd0, 1, 0, 0);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step(0, 0, 0, 3'd0, 1, 0, 0);
    step(0, 0, 0, 3'd0, 1, 0, 0);
    step(0, 0, 0, 3'd0, 1, 0, 0);

    // single-cycle windows back to back, 4-bit saturation
    do_reset();
    tid = 10;
    step(3, 1, 0, 3'd0, 1, 0, 0);
    for (int k = 1; k < 20; k++) begin
      step(3, 1, 1, 3'd0, 1, (k > 15) ? 15 : k, 0);
    end
    step(3, 0, 1, 3'd0, 1, 15, 0);
    step(3, 0, 0, 3'd0, 1, 15, 0);

    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
